text_vmem: RTL and testbench
============================

TEXT_VMEM -- requirements
Module: text_vmem

Interface
REQ-001 Parameter COLS, default 70, characters per text line.
REQ-002 Parameter ROWS, default 30, text lines on screen.
REQ-003 Parameter CHAR_H, default 16, pixel lines per character cell; power of two, 2..16.
REQ-004 Parameter BLINK_DIV, default 25000000, clk cycles per cursor blink half-period.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 key_in  in  8  ASCII code from keyboard front end.
REQ-008 p_valid  in  1  key_in valid; key consumed when p_valid && p_ready on a clk edge.
REQ-009 p_ready  out  1  block can accept a key this cycle.
REQ-010 x  in  XW=$clog2(COLS)  display column being fetched.
REQ-011 y  in  YW=$clog2(ROWS)  display line being fetched (0 = top of screen).
REQ-012 v_addr  in  10  current vertical pixel line.
REQ-013 ascii_out  out  8  character at (x,y), registered.
REQ-014 row  out  4  glyph pixel row = v_addr mod CHAR_H, zero-extended, registered.
REQ-015 cur_x / cur_y  out  XW / YW  cursor column / display line.

Function
REQ-016 Storage SHALL be COLS*ROWS bytes; physical line = (y + top) mod ROWS, top = scroll-offset register.
REQ-017 ascii_out and row SHALL appear one cycle after x/y/v_addr; reads never stall and are unaffected by writes except in the same-address cycle (new data returned).
REQ-018 FSM states: CLR_ALL, IDLE, CLR_LINE; p_ready=1 only in IDLE.
REQ-019 CLR_ALL: write 0x00 to every cell, one per cycle, COLS*ROWS cycles, then IDLE.
REQ-020 IDLE, printable key (0x20..0x7E): write at (cur_x,cur_y); cur_x+1; at cur_x==COLS-1, newline.
REQ-021 IDLE, 0x0A: newline; nothing written.
REQ-022 IDLE, 0x08: cur_x>0 -> cur_x-1, write 0x00 there; cur_x==0 && cur_y>0 -> cursor to (COLS-1,cur_y-1), write 0x00 there; (0,0) -> no-op.
REQ-023 Other codes SHALL be consumed with no effect.
REQ-024 Newline with cur_y<ROWS-1: cur_x=0, cur_y+1, stay IDLE.
REQ-025 Newline with cur_y==ROWS-1: top=(top+1) mod ROWS, cur_x=0, cur_y unchanged, enter CLR_LINE.
REQ-026 CLR_LINE: write 0x00 to the new bottom line over exactly COLS cycles, then IDLE.
REQ-027 Keys presented while p_ready=0 SHALL be neither consumed nor lost; the source holds them.

Reset
REQ-028 On reset assertion, immediately: cur_x=0, cur_y=0, top=0, ascii_out=0, row=0, p_ready=0, blink phase=0, state=CLR_ALL with clear counter 0.
REQ-029 Reset during CLR_LINE or CLR_ALL SHALL restart the full clear on release.
REQ-030 Memory contents are not reset; CLR_ALL guarantees zeros before the first key is accepted.

Configuration
REQ-031 Macro TEXT_VMEM_CURSOR_EN defined: blink counter toggles phase every BLINK_DIV cycles; while phase=1, a read at (cur_x,cur_y) returns 0x5F.
REQ-032 TEXT_VMEM_CURSOR_EN undefined: no blink counter, no overlay; ascii_out always memory contents; BLINK_DIV unused.

Verification
REQ-033 Release reset -> p_ready low for exactly COLS*ROWS cycles (2100 default); all reads then 0x00.
REQ-034 Send "AB" -> read (0,0)=0x41, (1,0)=0x42 one cycle after address; cur_x=2, cur_y=0.
REQ-035 Send 70 x 'a' -> cursor (0,1); 71st key lands at (0,1).
REQ-036 Fill line 29, send 0x0A -> p_ready low 70 cycles; old line 1 reads at y=0; y=29 all 0x00; cursor (0,29).
REQ-037 At (0,1) send 0x08 -> cursor (69,0), cell (69,0)=0x00; at (0,0) 0x08 -> no change.
REQ-038 With TEXT_VMEM_CURSOR_EN, BLINK_DIV=4 -> read at cursor alternates 0x5F / stored byte every 4 cycles; undefined -> stored byte always.

Source files
------------

// File: rtl/text_vmem_if.sv
// Bus bundle for text_vmem: keyboard handshake, display fetch address
// and the registered character/cursor outputs.
interface text_vmem_if #(
  parameter int XW = 7,
  parameter int YW = 5
);
  logic [7:0]    key_in;
  logic          p_valid;
  logic          p_ready;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [9:0]    v_addr;
  logic [7:0]    ascii_out;
  logic [3:0]    row;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  modport master (
    output key_in, p_valid, x, y, v_addr,
    input  p_ready, ascii_out, row, cur_x, cur_y
  );

  modport slave (
    input  key_in, p_valid, x, y, v_addr,
    output p_ready, ascii_out, row, cur_x, cur_y
  );
endinterface

// File: rtl/text_vmem.sv
// Text-mode video memory with a scrolling terminal-style writer.
// Characters arrive over a valid/ready handshake and are placed at the
// cursor; the display side fetches one cell per cycle with one cycle of
// latency. Scrolling rotates a top-line offset instead of moving data,
// then clears the line that becomes the new bottom.
//
// Build option: define TEXT_VMEM_CURSOR_EN to overlay a blinking '_'
// on the cursor cell (blink half-period BLINK_DIV clk cycles).
//
// state    | meaning
// ---------+-------------------------------------------------------
// CLR_ALL  | zero every cell, one per cycle, after reset
// IDLE     | accept keys (p_ready=1)
// CLR_LINE | zero the new bottom line after a scroll
module text_vmem #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int CHAR_H    = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  text_vmem_if.slave  bus
);

  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] clr_cnt, clr_cnt_n;
  logic [XW-1:0] cur_x, cur_x_n;
  logic [YW-1:0] cur_y, cur_y_n;
  logic [YW-1:0] top, top_n;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    ascii_q;
  logic [3:0]    row_q;
  logic          cursor_hit;

  // Map a display line to its physical line given the scroll offset.
  function automatic logic [YW-1:0] phys_line(input logic [YW-1:0] line,
                                              input logic [YW-1:0] t);
    logic [YW:0] s;
    s = {1'b0, line} + {1'b0, t};
    if (s >= (YW+1)'(ROWS)) s = s - (YW+1)'(ROWS);
    return s[YW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] line,
                                              input logic [XW-1:0] col);
    return AW'(line) * AW'(COLS) + AW'(col);
  endfunction

  logic [YW-1:0] cur_phys, prev_phys, rd_phys;
  logic [AW-1:0] rd_addr;
  logic          rd_in_range;
  logic          printable;
  logic          fire;

  assign cur_phys    = phys_line(cur_y, top);
  assign prev_phys   = phys_line(cur_y - YW'(1), top);
  assign rd_phys     = phys_line(bus.y, top);
  assign rd_addr     = cell_addr(rd_phys, bus.x);
  assign rd_in_range = (32'(bus.x) < COLS) && (32'(bus.y) < ROWS);
  assign printable   = (bus.key_in >= 8'h20) && (bus.key_in <= 8'h7E);
  assign fire        = (state == IDLE) && bus.p_valid;

  // State, cursor, scroll offset and clear counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLR_ALL;
      clr_cnt <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      top     <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      cur_x   <= cur_x_n;
      cur_y   <= cur_y_n;
      top     <= top_n;
    end
  end

  // Next-state, cursor movement and the single write port request.
  always_comb begin
    logic newline;
    state_n   = state;
    clr_cnt_n = clr_cnt;
    cur_x_n   = cur_x;
    cur_y_n   = cur_y;
    top_n     = top;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = 8'h00;
    newline   = 1'b0;

    unique case (state)
      CLR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + AW'(1);
        end
      end

      CLR_LINE: begin
        // top has already advanced, so cur_phys is the new bottom line
        wr_en   = 1'b1;
        wr_addr = cell_addr(cur_phys, XW'(clr_cnt));
        if (clr_cnt == AW'(COLS - 1)) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + AW'(1);
        end
      end

      IDLE: begin
        if (fire) begin
          if (printable) begin
            wr_en   = 1'b1;
            wr_data = bus.key_in;
            wr_addr = cell_addr(cur_phys, cur_x);
            if (cur_x == XW'(COLS - 1)) newline = 1'b1;
            else                        cur_x_n = cur_x + XW'(1);
          end else if (bus.key_in == 8'h0A) begin
            newline = 1'b1;
          end else if (bus.key_in == 8'h08) begin
            if (cur_x != '0) begin
              cur_x_n = cur_x - XW'(1);
              wr_en   = 1'b1;
              wr_addr = cell_addr(cur_phys, cur_x - XW'(1));
            end else if (cur_y != '0) begin
              cur_x_n = XW'(COLS - 1);
              cur_y_n = cur_y - YW'(1);
              wr_en   = 1'b1;
              wr_addr = cell_addr(prev_phys, XW'(COLS - 1));
            end
          end

          if (newline) begin
            cur_x_n = '0;
            if (cur_y != YW'(ROWS - 1)) begin
              cur_y_n = cur_y + YW'(1);
            end else begin
              top_n     = (top == YW'(ROWS - 1)) ? '0 : top + YW'(1);
              state_n   = CLR_LINE;
              clr_cnt_n = '0;
            end
          end
        end
      end

      default: begin
        state_n   = CLR_ALL;
        clr_cnt_n = '0;
      end
    endcase
  end

  // Character storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered fetch; a write to the fetched cell in the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii_q <= 8'h00;
      row_q   <= 4'h0;
    end else begin
      if (!rd_in_range)                       ascii_q <= 8'h00;
      else if (cursor_hit)                    ascii_q <= 8'h5F;
      else if (wr_en && (wr_addr == rd_addr)) ascii_q <= wr_data;
      else                                    ascii_q <= mem[rd_addr];
      row_q <= 4'(bus.v_addr & 10'(CHAR_H - 1));
    end
  end

`ifdef TEXT_VMEM_CURSOR_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Blink timer: down-count to zero, then flip phase and reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= BW'(BLINK_DIV - 1);
      blink_phase <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt   <= BW'(BLINK_DIV - 1);
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt - BW'(1);
    end
  end

  assign cursor_hit = blink_phase && (bus.x == cur_x) && (bus.y == cur_y);
`else
  // No overlay in this build; BLINK_DIV only keeps the parameter list
  // identical across builds and folds to a constant 0 here.
  assign cursor_hit = (BLINK_DIV < 0);
`endif

  assign bus.p_ready   = (state == IDLE);
  assign bus.ascii_out = ascii_q;
  assign bus.row       = row_q;
  assign bus.cur_x     = cur_x;
  assign bus.cur_y     = cur_y;

endmodule

// File: tb/tb_text_vmem.sv
// Directed bench for text_vmem: clear after reset, writing, wrap,
// backspace, scrolling, same-cycle read/write, cursor blink and
// reset during a line clear.
module tb_text_vmem;
  localparam int COLS = 70;
  localparam int ROWS = 30;
  localparam int XW   = 7;
  localparam int YW   = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  text_vmem_if #(.XW(XW), .YW(YW)) bus();

  text_vmem #(.COLS(COLS), .ROWS(ROWS), .CHAR_H(16), .BLINK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Hand a key over once p_ready is seen; returns at the negedge after
  // the consuming edge.
  task automatic send_key(input logic [7:0] k);
    int n = 0;
    while (!bus.p_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.p_ready) begin
      checks++;
      errors++;
      $display("FAIL send_key_wait: p_ready=%0b after %0d cycles, required 1", bus.p_ready, n);
    end
    bus.key_in  = k;
    bus.p_valid = 1'b1;
    @(negedge clk);
    bus.p_valid = 1'b0;
  endtask

  task automatic read_cell(input int cx, input int cy, output logic [7:0] d);
    bus.x = XW'(cx);
    bus.y = YW'(cy);
    @(negedge clk);
    d = bus.ascii_out;
  endtask

  task automatic test_reset;
    int n;
    logic [7:0] d;
    int tx[4] = '{1, 69, 35, 0};
    int ty[4] = '{0, 29, 15, 29};
    bus.key_in  = 8'h00;
    bus.p_valid = 1'b0;
    bus.x       = '0;
    bus.y       = '0;
    bus.v_addr  = 10'h005;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.p_ready !== 1'b0) begin errors++; $display("FAIL reset_p_ready: got %0b required 0", bus.p_ready); end
    checks++; if (bus.cur_x !== 7'd0) begin errors++; $display("FAIL reset_cur_x: got %0d required 0", bus.cur_x); end
    checks++; if (bus.cur_y !== 5'd0) begin errors++; $display("FAIL reset_cur_y: got %0d required 0", bus.cur_y); end
    checks++; if (bus.ascii_out !== 8'h00) begin errors++; $display("FAIL reset_ascii: got %h required 00", bus.ascii_out); end
    checks++; if (bus.row !== 4'h0) begin errors++; $display("FAIL reset_row: got %0d required 0", bus.row); end
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.p_ready && n < 5000);
    checks++; if (n != 2100) begin errors++; $display("FAIL clr_all_cycles: got %0d required 2100", n); end
    for (int i = 0; i < 4; i++) begin
      read_cell(tx[i], ty[i], d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL clr_all_read(%0d,%0d): got %h required 00", tx[i], ty[i], d); end
    end
  endtask

  task automatic test_row;
    bus.v_addr = 10'h123;
    @(negedge clk);
    checks++; if (bus.row !== 4'd3) begin errors++; $display("FAIL row_123: got %0d required 3", bus.row); end
    bus.v_addr = 10'h3FF;
    @(negedge clk);
    checks++; if (bus.row !== 4'd15) begin errors++; $display("FAIL row_3ff: got %0d required 15", bus.row); end
    bus.v_addr = 10'h010;
    @(negedge clk);
    checks++; if (bus.row !== 4'd0) begin errors++; $display("FAIL row_010: got %0d required 0", bus.row); end
  endtask

  task automatic test_ab;
    logic [7:0] d;
    send_key(8'h41);
    send_key(8'h42);
    checks++; if (bus.cur_x !== 7'd2 || bus.cur_y !== 5'd0) begin errors++; $display("FAIL ab_cursor: got (%0d,%0d) required (2,0)", bus.cur_x, bus.cur_y); end
    read_cell(0, 0, d);
    checks++; if (d !== 8'h41) begin errors++; $display("FAIL ab_read00: got %h required 41", d); end
    read_cell(1, 0, d);
    checks++; if (d !== 8'h42) begin errors++; $display("FAIL ab_read10: got %h required 42", d); end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    int tx[3] = '{69, 2, 0};
    logic [7:0] ex[3] = '{8'h61, 8'h61, 8'h41};
    for (int i = 0; i < 68; i++) send_key(8'h61);
    checks++; if (bus.cur_x !== 7'd0 || bus.cur_y !== 5'd1) begin errors++; $display("FAIL wrap_cursor: got (%0d,%0d) required (0,1)", bus.cur_x, bus.cur_y); end
    for (int i = 0; i < 3; i++) begin
      read_cell(tx[i], 0, d);
      checks++;
      if (d !== ex[i]) begin errors++; $display("FAIL wrap_read(%0d,0): got %h required %h", tx[i], d, ex[i]); end
    end
    send_key(8'h5A);
    checks++; if (bus.cur_x !== 7'd1 || bus.cur_y !== 5'd1) begin errors++; $display("FAIL wrap_next_cursor: got (%0d,%0d) required (1,1)", bus.cur_x, bus.cur_y); end
    read_cell(0, 1, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL wrap_next_read: got %h required 5a", d); end
  endtask

  task automatic test_backspace;
    logic [7:0] d;
    send_key(8'h08);
    checks++; if (bus.cur_x !== 7'd0 || bus.cur_y !== 5'd1) begin errors++; $display("FAIL bs1_cursor: got (%0d,%0d) required (0,1)", bus.cur_x, bus.cur_y); end
    send_key(8'h08);
    checks++; if (bus.cur_x !== 7'd69 || bus.cur_y !== 5'd0) begin errors++; $display("FAIL bs_up_cursor: got (%0d,%0d) required (69,0)", bus.cur_x, bus.cur_y); end
    read_cell(68, 0, d);
    checks++; if (d !== 8'h61) begin errors++; $display("FAIL bs_keep68: got %h required 61", d); end
    read_cell(0, 1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bs_clear01: got %h required 00", d); end
    for (int i = 0; i < 69; i++) send_key(8'h08);
    checks++; if (bus.cur_x !== 7'd0 || bus.cur_y !== 5'd0) begin errors++; $display("FAIL bs_home_cursor: got (%0d,%0d) required (0,0)", bus.cur_x, bus.cur_y); end
    read_cell(69, 0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bs_clear690: got %h required 00", d); end
    read_cell(1, 0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bs_clear10: got %h required 00", d); end
    send_key(8'h08);
    checks++; if (bus.cur_x !== 7'd0 || bus.cur_y !== 5'd0) begin errors++; $display("FAIL bs_origin_noop: got (%0d,%0d) required (0,0)", bus.cur_x, bus.cur_y); end
  endtask

  task automatic test_other_codes;
    logic [7:0] d;
    send_key(8'h51);
    send_key(8'h7F);
    send_key(8'h01);
    send_key(8'h0D);
    checks++; if (bus.cur_x !== 7'd1 || bus.cur_y !== 5'd0) begin errors++; $display("FAIL other_cursor: got (%0d,%0d) required (1,0)", bus.cur_x, bus.cur_y); end
    read_cell(0, 0, d);
    checks++; if (d !== 8'h51) begin errors++; $display("FAIL other_read00: got %h required 51", d); end
    read_cell(1, 0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL other_read10: got %h required 00", d); end
  endtask

  task automatic test_scroll;
    int n;
    logic [7:0] d;
    int tx[9] = '{0, 1, 2, 5, 68, 69, 1, 35, 69};
    int ty[9] = '{0, 0, 0, 28, 28, 28, 29, 29, 29};
    logic [7:0] ex[9] = '{8'h4D, 8'h4E, 8'h00, 8'h78, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
    send_key(8'h0A);
    send_key(8'h4D);
    send_key(8'h4E);
    for (int i = 0; i < 28; i++) send_key(8'h0A);
    checks++; if (bus.cur_x !== 7'd0 || bus.cur_y !== 5'd29) begin errors++; $display("FAIL scroll_pre_cursor: got (%0d,%0d) required (0,29)", bus.cur_x, bus.cur_y); end
    for (int i = 0; i < 69; i++) send_key(8'h78);
    send_key(8'h0A);
    n = 0;
    while (!bus.p_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 70) begin errors++; $display("FAIL clr_line_cycles: got %0d required 70", n); end
    checks++; if (bus.cur_x !== 7'd0 || bus.cur_y !== 5'd29) begin errors++; $display("FAIL scroll_cursor: got (%0d,%0d) required (0,29)", bus.cur_x, bus.cur_y); end
    for (int i = 0; i < 9; i++) begin
      read_cell(tx[i], ty[i], d);
      checks++;
      if (d !== ex[i]) begin errors++; $display("FAIL scroll_read(%0d,%0d): got %h required %h", tx[i], ty[i], d, ex[i]); end
    end
  endtask

  task automatic test_same_addr;
    logic [7:0] d;
`ifndef TEXT_VMEM_CURSOR_EN
    bus.x = 7'd0;
    bus.y = 5'd29;
    checks++; if (bus.p_ready !== 1'b1) begin errors++; $display("FAIL same_addr_ready: got %0b required 1", bus.p_ready); end
    bus.key_in  = 8'h57;
    bus.p_valid = 1'b1;
    @(negedge clk);
    bus.p_valid = 1'b0;
    checks++; if (bus.ascii_out !== 8'h57) begin errors++; $display("FAIL same_addr_read: got %h required 57", bus.ascii_out); end
`else
    send_key(8'h57);
`endif
    read_cell(0, 29, d);
    checks++; if (d !== 8'h57) begin errors++; $display("FAIL same_addr_after: got %h required 57", d); end
    checks++; if (bus.cur_x !== 7'd1 || bus.cur_y !== 5'd29) begin errors++; $display("FAIL same_addr_cursor: got (%0d,%0d) required (1,29)", bus.cur_x, bus.cur_y); end
  endtask

  task automatic test_blink;
    logic [7:0] v[20];
    bus.x = 7'd0;
    bus.y = 5'd29;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ascii_out !== 8'h57) begin errors++; $display("FAIL blink_off_cursor[%0d]: got %h required 57", i, bus.ascii_out); end
    end
    bus.x = 7'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v[i] = bus.ascii_out;
    end
`ifdef TEXT_VMEM_CURSOR_EN
    begin
      int i0 = 0;
      for (int i = 19; i >= 1; i--) if (v[i] !== v[i-1]) i0 = i;
      checks++;
      if (i0 == 0 || i0 > 4) begin
        errors++;
        $display("FAIL blink_first_toggle: got index %0d required 1..4", i0);
      end else begin
        checks++;
        if ((v[i0] ^ v[i0-1]) !== 8'h5F) begin errors++; $display("FAIL blink_values: got %h/%h required 5f/00", v[i0], v[i0-1]); end
        for (int j = i0; j < i0 + 12; j++) begin
          logic [7:0] e;
          e = (((j - i0) / 4) % 2 == 0) ? v[i0] : v[i0-1];
          checks++;
          if (v[j] !== e) begin errors++; $display("FAIL blink_period[%0d]: got %h required %h", j, v[j], e); end
        end
      end
    end
`else
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (v[i] !== 8'h00) begin errors++; $display("FAIL no_blink[%0d]: got %h required 00", i, v[i]); end
    end
`endif
  endtask

  task automatic test_reset_restart;
    int n;
    logic [7:0] d;
    send_key(8'h0A);
    bus.x = 7'd5;
    bus.y = 5'd27;
    @(negedge clk);
    checks++; if (bus.p_ready !== 1'b0) begin errors++; $display("FAIL restart_in_clr_line: p_ready got %0b required 0", bus.p_ready); end
    checks++; if (bus.ascii_out !== 8'h78) begin errors++; $display("FAIL read_during_clear: got %h required 78", bus.ascii_out); end
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.ascii_out !== 8'h00) begin errors++; $display("FAIL restart_ascii: got %h required 00", bus.ascii_out); end
    checks++; if (bus.cur_x !== 7'd0 || bus.cur_y !== 5'd0) begin errors++; $display("FAIL restart_cursor: got (%0d,%0d) required (0,0)", bus.cur_x, bus.cur_y); end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.p_ready && n < 5000);
    checks++; if (n != 2100) begin errors++; $display("FAIL restart_clr_cycles: got %0d required 2100", n); end
    read_cell(5, 27, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL restart_read527: got %h required 00", d); end
    read_cell(0, 28, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL restart_read028: got %h required 00", d); end
  endtask

  initial begin
    test_reset();
    test_row();
    test_ab();
    test_wrap();
    test_backspace();
    test_other_codes();
    test_scroll();
    test_same_addr();
    test_blink();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
